// File: rtl/pipelined_barrel_shifter_valid_ready.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter_valid_ready
//
// Logarithmic barrel shifter with a run-time shift amount and direction.
// Stage k shifts by 2^k when bit k of the carried shift amount is set, so an
// N-bit operand passes through SW = log2(N) register stages. Each stage carries
// its own valid bit, and a combinational ready chain lets the pipeline stall
// from the output side while empty stages still fill (bubble squeezing).
//
// Supported shifts: logical left, logical right, arithmetic right (sign fill).
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset (clears all stages)
//   up_valid    input transfer valid
//   up_ready    shifter can accept an input this cycle
//   up_data     operand, N bits
//   up_shamt    shift amount 0..N-1, SW bits
//   up_left     1 = shift left, 0 = shift right
//   up_arith    1 = arithmetic right shift (ignored when up_left = 1)
//   down_valid  result valid (registered)
//   down_ready  consumer accepts the result this cycle
//   down_data   shifted result, N bits (registered)
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter_valid_ready #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    input  logic          up_left,
    input  logic          up_arith,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    // One shift step by a fixed power-of-two amount. Right shifts OR in the
    // fill mask so arithmetic shifts replicate the original sign bit.
    function automatic logic [N-1:0] shift_step(
        input logic [N-1:0] x,
        input int           amt,
        input logic         left,
        input logic         fill
    );
        logic [N-1:0] fill_mask;
        fill_mask = ~({N{1'b1}} >> amt);
        if (left)
            return x << amt;
        else if (fill)
            return (x >> amt) | fill_mask;
        else
            return x >> amt;
    endfunction

    // Per-stage registers
    logic [SW-1:0]         vld;
    logic [SW-1:0][N-1:0]  dat;
    logic [SW-1:0][SW-1:0] shamt;
    logic [SW-1:0]         left;
    logic [SW-1:0]         arith;
    logic [SW-1:0]         sign;

    // Inputs seen by each stage: the upstream port for stage 0, otherwise
    // the registers of the preceding stage.
    logic [SW-1:0]         in_v;
    logic [SW-1:0][N-1:0]  in_d;
    logic [SW-1:0][SW-1:0] in_shamt;
    logic [SW-1:0]         in_left;
    logic [SW-1:0]         in_arith;
    logic [SW-1:0]         in_sign;

    logic [SW-1:0]         rdy;

    always_comb begin
        in_v     = '0;
        in_d     = '0;
        in_shamt = '0;
        in_left  = '0;
        in_arith = '0;
        in_sign  = '0;
        in_v[0]     = up_valid;
        in_d[0]     = up_data;
        in_shamt[0] = up_shamt;
        in_left[0]  = up_left;
        in_arith[0] = up_arith;
        in_sign[0]  = up_data[N-1];
        for (int k = 1; k < SW; k++) begin
            in_v[k]     = vld[k-1];
            in_d[k]     = dat[k-1];
            in_shamt[k] = shamt[k-1];
            in_left[k]  = left[k-1];
            in_arith[k] = arith[k-1];
            in_sign[k]  = sign[k-1];
        end
    end

    // Ready chain, walked from the output back to the input: a stage may load
    // if it is empty or if everything downstream of it is moving.
    always_comb begin
        logic acc;
        acc = down_ready;
        rdy = '0;
        for (int k = SW - 1; k >= 0; k--) begin
            acc    = !vld[k] || acc;
            rdy[k] = acc;
        end
    end

    assign up_ready = rdy[0];

    // Stage registers: stage k applies the 2^k step selected by shamt bit k
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            dat   <= '0;
            shamt <= '0;
            left  <= '0;
            arith <= '0;
            sign  <= '0;
        end else begin
            for (int k = 0; k < SW; k++) begin
                if (rdy[k]) begin
                    vld[k]   <= in_v[k];
                    dat[k]   <= in_shamt[k][k]
                                ? shift_step(in_d[k], 1 << k, in_left[k],
                                             in_arith[k] && in_sign[k])
                                : in_d[k];
                    shamt[k] <= in_shamt[k];
                    left[k]  <= in_left[k];
                    arith[k] <= in_arith[k];
                    sign[k]  <= in_sign[k];
                end
            end
        end
    end

    // Output stage
    assign down_valid = vld[SW-1];
    assign down_data  = dat[SW-1];

    // The last stage's carried control has no consumer; the lower shift-amount
    // bits are likewise only needed by earlier stages.
    logic ctrl_unused;
    assign ctrl_unused = ^{in_shamt, shamt[SW-1], left[SW-1], arith[SW-1], sign[SW-1]};

endmodule
